uart_rx_param: RTL

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_rx_param.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: parameterised UART receiver with optional parity (enable with UART_RX_PARITY_EN)
module uart_rx_param #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 start_rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);
  localparam int BIT_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_BIT_TIME = BIT_TIME / 2;
  localparam int CW = BIT_TIME > 2 ? $clog2(BIT_TIME) : 1;
  localparam logic [CW-1:0] BIT_END = CW'(BIT_TIME - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT_TIME - 1);
  localparam logic [3:0] DATA_END = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_END = 4'(STOP_BITS - 1);
  if (DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
      (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_cfg
    $error("uart_rx_param: illegal parameter set");
  end
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state_q, state_d;
  logic s1_q, s2_q, rxs;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, dout_q, dout_d;
  logic ferr_q, ferr_d, frerr_q, frerr_d, dv_q, dv_d, armed_q, armed_d;
`ifdef UART_RX_PARITY_EN
  logic par_q, par_d, perr_q, perr_d;
`endif
  assign rxs = s2_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    bcnt_d = bcnt_q;
    shift_d = shift_q;
    ferr_d = ferr_q;
    dout_d = dout_q;
    frerr_d = frerr_q;
    dv_d = 1'b0;
    armed_d = armed_q | rxs;
`ifdef UART_RX_PARITY_EN
    par_d = par_q;
    perr_d = perr_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        state_d = (start_rx && !rxs && armed_q) ? START : IDLE;
      end
      START: begin
        if (cnt_q == HALF_END) begin
          cnt_d = '0;
          bcnt_d = '0;
          state_d = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};
          bcnt_d = bcnt_q == DATA_END ? 4'd0 : bcnt_q + 1'b1;
          ferr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
          state_d = bcnt_q == DATA_END ? PARITY : DATA;
`else
          state_d = bcnt_q == DATA_END ? STOP : DATA;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          par_d = rxs;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          bcnt_d = bcnt_q + 1'b1;
          ferr_d = ferr_q | !rxs;
          if (bcnt_q == STOP_END) begin
            state_d = IDLE;
            bcnt_d = '0;
            dv_d = 1'b1;
            dout_d = shift_q;
            frerr_d = ferr_q | !rxs;
            armed_d = (ferr_q | !rxs) ? 1'b0 : armed_q | rxs;
`ifdef UART_RX_PARITY_EN
            perr_d = (^shift_q ^ par_q) != 1'(PARITY_ODD);
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      cnt_q <= '0;
      bcnt_q <= '0;
      shift_q <= '0;
      ferr_q <= 1'b0;
      dout_q <= '0;
      frerr_q <= 1'b0;
      dv_q <= 1'b0;
      armed_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_q <= 1'b0;
      perr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s1_q <= rx;
      s2_q <= s1_q;
      cnt_q <= cnt_d;
      bcnt_q <= bcnt_d;
      shift_q <= shift_d;
      ferr_q <= ferr_d;
      dout_q <= dout_d;
      frerr_q <= frerr_d;
      dv_q <= dv_d;
      armed_q <= armed_d;
`ifdef UART_RX_PARITY_EN
      par_q <= par_d;
      perr_q <= perr_d;
`endif
    end
  end
  assign data_out = dout_q;
  assign data_valid = dv_q;
  assign frame_err = frerr_q;
  assign busy = state_q != IDLE;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif
endmodule
